// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync checker: recovers x/y position, data enable and
// frame start from hsync/vsync, validates timing and reports lock/errors.
module vga_sync_decoder #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_TOTAL     = 800,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_TOTAL     = 525,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync,
    input  logic          vsync,
    output logic [CW-1:0] x_pos,
    output logic [CW-1:0] y_pos,
    output logic          de,
    output logic          frame_start,
    output logic          locked,
    output logic          timing_err,
    output logic [7:0]    err_count
);

    localparam int WW = CW + 1;
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [WW-1:0] WD_LIM = WW'(2 * H_TOTAL);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

    state_e        state_q, state_d;
    logic          hs_q, hs_q2, vs_q, vs_q2;
    logic          hs_rise, hs_fall, vs_rise;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] per_q, per_d, pw_q, pw_d, lines_q, lines_d;
    logic [CW-1:0] per_inc, lines_cnt;
    logic [WW-1:0] wd_q, wd_d;
    logic [3:0]    good_q, good_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          armed_q, armed_d, bad_q, bad_d;
    logic          locked_q, locked_d, err_q, err_d;
    logic          line_fail, frame_fail, nosig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= ~SYNC_POL;
            hs_q2 <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            vs_q2 <= ~SYNC_POL;
        end else begin
            hs_q  <= hsync;
            hs_q2 <= hs_q;
            vs_q  <= vsync;
            vs_q2 <= vs_q;
        end
    end

    assign hs_rise = (hs_q == SYNC_POL) && (hs_q2 != SYNC_POL);
    assign hs_fall = (hs_q != SYNC_POL) && (hs_q2 == SYNC_POL);
    assign vs_rise = (vs_q == SYNC_POL) && (vs_q2 != SYNC_POL);

    // Measurement counters saturate so a missing edge can never alias to a good value
    always_comb begin
        per_inc = per_q;
        if (per_q != CMAX) per_inc = per_q + 1'b1;
        lines_cnt = lines_q;
        if (hs_rise && lines_q != CMAX) lines_cnt = lines_q + 1'b1;
        line_fail = hs_rise && armed_q &&
                    (per_q != CW'(H_TOTAL) || pw_q != CW'(H_SYNC));
        frame_fail = vs_rise &&
                     (lines_cnt != CW'(V_TOTAL) || bad_q || line_fail);
        nosig = !hs_rise && (wd_q == WD_LIM - 1'b1);
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (nosig) begin
                    state_d = SEARCH;
                end else if (line_fail || frame_fail) begin
                    good_d = '0;
                end else if (vs_rise) begin
                    good_d = good_q + 4'd1;
                    if (good_d >= 4'(LOCK_FRAMES)) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (nosig || line_fail || frame_fail) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        x_d = (x_q == CW'(H_TOTAL - 1)) ? '0 : x_q + 1'b1;
        if (hs_rise) x_d = CW'(H_VIS + H_FP);
        y_d = y_q;
        if (vs_rise) begin
            y_d = CW'(V_VIS + V_FP);
        end else if (!hs_rise && x_q == CW'(H_TOTAL - 1)) begin
            y_d = (y_q == CW'(V_TOTAL - 1)) ? '0 : y_q + 1'b1;
        end
        per_d   = hs_rise ? CW'(1) : per_inc;
        pw_d    = hs_rise ? '0 : (hs_fall ? per_q : pw_q);
        lines_d = vs_rise ? '0 : lines_cnt;
        wd_d    = hs_rise ? '0 : ((wd_q == WD_LIM) ? wd_q : wd_q + 1'b1);
        armed_d = hs_rise | armed_q;
        if (state_d == SEARCH && state_q != SEARCH) armed_d = 1'b0;
        bad_d    = vs_rise ? 1'b0 : (bad_q | line_fail);
        locked_d = (state_q == LOCKED);
        cnt_d    = (err_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            x_q      <= '0;
            y_q      <= '0;
            per_q    <= '0;
            pw_q     <= '0;
            lines_q  <= '0;
            wd_q     <= '0;
            good_q   <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            bad_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            per_q    <= per_d;
            pw_q     <= pw_d;
            lines_q  <= lines_d;
            wd_q     <= wd_d;
            good_q   <= good_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign locked      = locked_q;
    assign timing_err  = err_q;
    assign err_count   = cnt_q;
    assign de          = locked_q && x_q < CW'(H_VIS) && y_q < CW'(V_VIS);
    assign frame_start = locked_q && x_q == '0 && y_q == '0;

endmodule
